qa_dsm_status_writer: RTL

- Host-bound counterpart of the CSR receive path: the host configures the device status memory (DSM) base through CSR writes, and this block writes AFU status back into that DSM region.
- Once the DSM base is valid, it writes the AFU ID cache line (line 0).
- It then drains a small FIFO of status-update requests from other AFU blocks, issuing full-line writes on the TX write channel (tx1).
- It tracks outstanding writes using the RX write-response channel (rx1).

---
 rtl/qa_dsm_status_writer_if.sv | 26 ++
 rtl/qa_dsm_status_writer.sv | 114 +++++++++++
 2 files changed

// File: rtl/qa_dsm_status_writer_if.sv
// Status-request, TX write-channel and RX write-response signals of the DSM status writer.
// The master side is the writer itself; the slave side is the requesting blocks plus the host link.
interface qa_dsm_status_writer_if #(
  parameter int LINE_IDX_BITS = 6
);
  logic                     st_req_valid;
  logic [LINE_IDX_BITS-1:0] st_req_line;
  logic [63:0]              st_req_data;
  logic                     st_req_ready;
  logic                     tx1_almost_full;
  logic                     tx1_wr_valid;
  logic [57:0]              tx1_wr_addr;
  logic [7:0]               tx1_wr_mdata;
  logic [511:0]             tx1_wr_data;
  logic                     rx1_wr_rsp;

  modport master (
    input  st_req_valid, st_req_line, st_req_data, tx1_almost_full, rx1_wr_rsp,
    output st_req_ready, tx1_wr_valid, tx1_wr_addr, tx1_wr_mdata, tx1_wr_data
  );

  modport slave (
    output st_req_valid, st_req_line, st_req_data, tx1_almost_full, rx1_wr_rsp,
    input  st_req_ready, tx1_wr_valid, tx1_wr_addr, tx1_wr_mdata, tx1_wr_data
  );
endinterface

// File: rtl/qa_dsm_status_writer.sv
// Writes the AFU ID line and queued status updates into the host DSM region,
// tracking writes in flight against the write-response channel.
module qa_dsm_status_writer #(
  parameter logic [127:0] AFU_ID          = 128'h0,
  parameter int           FIFO_DEPTH      = 4,
  parameter int           MAX_OUTSTANDING = 8,
  parameter int           LINE_IDX_BITS   = 6
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic [63:0]                   dsm_base,
  input  logic                          dsm_base_valid,
  input  logic                          dsm_base_wr,
  qa_dsm_status_writer_if.master        bus,
  output logic [7:0]                    outstanding,
  output logic                          idle
);

  localparam int                  PTR_BITS  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                  CNT_BITS  = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);
  localparam logic [7:0]          MAX_OUT   = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {WAIT_BASE, WRITE_ID, RUN} state_t;

  state_t                   state, state_nxt;
  logic [LINE_IDX_BITS-1:0] fifo_line [FIFO_DEPTH];
  logic [63:0]              fifo_data [FIFO_DEPTH];
  logic [PTR_BITS-1:0]      wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]      count;
  logic [57:0]              base_line;
  logic [7:0]               tag;
  logic                     can_issue, push, pop, issue_id, issue, rsp_dec;
  logic                     unused_base_lsbs;

  assign unused_base_lsbs = ^dsm_base[5:0];

  assign can_issue        = !bus.tx1_almost_full && (outstanding < MAX_OUT);
  assign bus.st_req_ready = resetb && (state != WAIT_BASE) && (count < DEPTH_CNT);
  assign push             = bus.st_req_valid && bus.st_req_ready;
  assign issue_id         = (state == WRITE_ID) && can_issue;
  assign pop              = (state == RUN) && can_issue && (count != '0);
  assign issue            = issue_id || pop;
  assign rsp_dec          = bus.rx1_wr_rsp && (outstanding != 8'd0);
  assign idle             = (state == RUN) && (count == '0) && (outstanding == 8'd0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= WAIT_BASE;
    else         state <= state_nxt;
  end

  // A base rewrite always sends us back to republish the AFU ID at the new base.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_BASE: if (dsm_base_valid) state_nxt = WRITE_ID;
      WRITE_ID:  if (dsm_base_wr) state_nxt = WRITE_ID;
                 else if (can_issue) state_nxt = RUN;
      RUN:       if (dsm_base_wr) state_nxt = WRITE_ID;
      default:   state_nxt = WAIT_BASE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_line[wr_ptr] <= bus.st_req_line;
      fifo_data[wr_ptr] <= bus.st_req_data;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Status lines are addressed from the base latched with the last AFU ID write,
  // so a pop racing a base rewrite still lands at the old base.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bus.tx1_wr_valid <= 1'b0;
      bus.tx1_wr_addr  <= '0;
      bus.tx1_wr_data  <= '0;
      bus.tx1_wr_mdata <= '0;
      base_line        <= '0;
      tag              <= '0;
      outstanding      <= '0;
    end else begin
      bus.tx1_wr_valid <= issue;
      if (issue_id) begin
        bus.tx1_wr_addr <= dsm_base[63:6];
        bus.tx1_wr_data <= {384'b0, AFU_ID};
        base_line       <= dsm_base[63:6];
      end else if (pop) begin
        bus.tx1_wr_addr <= base_line + {{(58-LINE_IDX_BITS){1'b0}}, fifo_line[rd_ptr]};
        bus.tx1_wr_data <= {448'b0, fifo_data[rd_ptr]};
      end
      if (issue) begin
        bus.tx1_wr_mdata <= tag;
        tag              <= tag + 8'd1;
      end
      if (issue && !rsp_dec)      outstanding <= outstanding + 8'd1;
      else if (!issue && rsp_dec) outstanding <= outstanding - 8'd1;
    end
  end

endmodule
